// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control sequencer: fetch, decode, execute, memory, writeback.
// Strobes are decoded from the registered state and current inputs; retired instructions are counted.
module cpu_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic [10:0] ALUCtl_code,
  input  logic        execute_flag,
  input  logic        cpsr_enable,
  output logic        imem_req,
  output logic        ir_load,
  output logic        decode_enable,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        mem_data_load,
  output logic        rf_write,
  output logic [1:0]  rf_wsel,
  output logic        cpsr_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        retire,
  output logic        squash,
  output logic        illegal,
  output logic [2:0]  state,
  output logic [15:0] retire_count
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_e;

  localparam logic [10:0] OP_B   = 11'd31;
  localparam logic [10:0] OP_BL  = 11'd32;
  localparam logic [10:0] OP_LDR = 11'd41;
  localparam logic [10:0] OP_STR = 11'd42;

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;

  state_e      state_q, state_d;
  logic [10:0] op_q, op_d;
  logic [15:0] retire_count_q, retire_count_d;

  logic op_dp, op_nowb, op_b, op_bl, op_ldr, op_str;

  assign op_dp   = (op_q <= 11'd13);
  assign op_nowb = (op_q == 11'd8) || (op_q == 11'd9) || (op_q == 11'd10) || (op_q == 11'd13);
  assign op_b    = (op_q == OP_B);
  assign op_bl   = (op_q == OP_BL);
  assign op_ldr  = (op_q == OP_LDR);
  assign op_str  = (op_q == OP_STR);

  assign state        = state_q;
  assign retire_count = retire_count_q;

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    retire_count_d = retire_count_q;
    imem_req       = 1'b0;
    ir_load        = 1'b0;
    decode_enable  = 1'b0;
    dmem_req       = 1'b0;
    dmem_we        = 1'b0;
    mem_data_load  = 1'b0;
    rf_write       = 1'b0;
    rf_wsel        = WSEL_ALU;
    cpsr_write     = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    retire         = 1'b0;
    squash         = 1'b0;
    illegal        = 1'b0;

    case (state_q)
      // FETCH is the reset state, so its strobes are masked while reset is held
      FETCH: begin
        imem_req = ~reset;
        if (imem_ack && !reset) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end
      end

      DECODE: begin
        decode_enable = 1'b1;
        op_d          = ALUCtl_code;
        state_d       = EXECUTE;
      end

      EXECUTE: begin
        decode_enable = 1'b1;
        state_d       = FETCH;
        if (!execute_flag) begin
          pc_write = 1'b1;
          squash   = 1'b1;
        end else if (op_dp) begin
          cpsr_write = cpsr_enable;
          state_d    = WRITEBACK;
        end else if (op_b || op_bl) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
          retire   = 1'b1;
          if (op_bl) begin
            rf_write = 1'b1;
            rf_wsel  = WSEL_LINK;
          end
        end else if (op_ldr || op_str) begin
          state_d = MEMORY;
        end else begin
          illegal  = 1'b1;
          pc_write = 1'b1;
        end
      end

      MEMORY: begin
        decode_enable = 1'b1;
        dmem_req      = 1'b1;
        dmem_we       = op_str;
        if (dmem_ack) begin
          if (op_str) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
          end else begin
            mem_data_load = 1'b1;
            state_d       = WRITEBACK;
          end
        end
      end

      WRITEBACK: begin
        decode_enable = 1'b1;
        rf_write      = ~op_nowb;
        rf_wsel       = op_ldr ? WSEL_MEM : WSEL_ALU;
        pc_write      = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end

      default: state_d = FETCH;
    endcase

    if (retire) begin
      retire_count_d = retire_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= FETCH;
      op_q           <= 11'd0;
      retire_count_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      retire_count_q <= retire_count_d;
    end
  end

endmodule
